spi_master_engine: RTL

- SPI master shift engine, directly downstream of the Avalon-MM SPI register block.
- Consumes ClockDiv, Start and DataIn from the register block; returns Busy and DataOut.
- Drives the off-chip SPI pins. Fixed protocol: mode 0 (CPOL=0, CPHA=0), MSB first, single chip select, one DATA_W-bit full-duplex word per Start.

---
 rtl/spi_master_engine_if.sv | 29 ++
 rtl/spi_master_engine.sv | 115 +++++++++++
 2 files changed

// File: rtl/spi_master_engine_if.sv
// Register-block-facing controls plus the off-chip SPI pins of the shift engine.
// Start is a one-cycle request and is honoured only while Busy=0. Busy covers the whole
// transfer, and Done pulses for one cycle, together with the DataOut update, as Busy falls.
interface spi_master_engine_if #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
);
  logic [DIV_W-1:0]  ClockDiv;
  logic              Start;
  logic [DATA_W-1:0] DataIn;
  logic              Busy;
  logic [DATA_W-1:0] DataOut;
  logic              Done;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              cs_n;
  logic [1:0]        dbg_state;

  modport master (
    output ClockDiv, Start, DataIn, miso,
    input  Busy, DataOut, Done, sclk, mosi, cs_n, dbg_state
  );

  modport slave (
    input  ClockDiv, Start, DataIn, miso,
    output Busy, DataOut, Done, sclk, mosi, cs_n, dbg_state
  );
endinterface

// File: rtl/spi_master_engine.sv
// SPI mode-0 master shift engine: MSB first, one full-duplex DATA_W-bit word per Start.
// A transfer is SETUP (H) + 2*DATA_W half-periods of SHIFT + HOLD (H), with H = ClockDiv+1.
module spi_master_engine #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic clk,
  input  logic rst,
  spi_master_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

  state_t            state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  hcnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] data_out_q;
  logic              sclk_q;
  logic              cs_n_q;
  logic              busy_q;
  logic              done_q;
  logic              half_end;

  assign half_end = (hcnt == div_q);

  assign bus.sclk      = sclk_q;
  assign bus.mosi      = tx_q[DATA_W-1];
  assign bus.cs_n      = cs_n_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DataOut   = data_out_q;
  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_q      <= '0;
      hcnt       <= '0;
      bit_cnt    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          sclk_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          hcnt    <= '0;
          bit_cnt <= '0;
          if (bus.Start) begin
            tx_q   <= bus.DataIn;
            div_q  <= bus.ClockDiv;
            cs_n_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            hcnt    <= '0;
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[DATA_W-2:0], bus.miso};
            bit_cnt <= bit_cnt + CNT_W'(1);
            state   <= SHIFT;
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (half_end) begin
            hcnt <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              // After the last sample mosi keeps bit 0 through the final low half-period and HOLD.
              if (bit_cnt != LAST_BIT) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
            end else if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              sclk_q  <= 1'b1;
              rx_q    <= {rx_q[DATA_W-2:0], bus.miso};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (half_end) begin
            hcnt       <= '0;
            data_out_q <= rx_q;
            done_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_q       <= '0;
            state      <= IDLE;
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
